gps_nav_msg_gen: RTL and testbench

- Navigation-data source that directly feeds the `msg_in` input of the GPS signal-generation core.
- Emits a framed bit stream: an 8-bit preamble followed by a 32-bit payload word, MSB first, repeating.
- Each bit lasts 20 C/A code periods, aligned to the core's code-phase counter (same reset, same enable).
- Payload words come from a one-entry valid/ready load buffer, or from a fixed preset word when no user word is supplied.

---
 rtl/gps_nav_msg_gen.sv | 235 +++++++++++++++++++++++
 tb/tb_gps_nav_msg_gen.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gps_nav_msg_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : gps_nav_msg_gen
// Purpose  : Navigation-data bit source for the GPS signal-generation core.
//            Emits repeating frames of an 8-bit preamble followed by a 32-bit
//            payload word, MSB first. Each bit lasts EPOCHS_PER_BIT code
//            periods of SAMPLES_PER_EPOCH enabled cycles, so the bit edges
//            line up with the core's code-phase counter (same reset/enable).
//            Payload comes from a one-entry valid/ready load buffer or, when
//            no user word is available / selected, from PRESET_WORD.
// Ports    : clk_in           clock
//            rst_in_n         asynchronous active-low reset
//            ena_in           timing enable shared with the signal core
//            src_sel_in       0 = preset payload, 1 = buffered user payload
//            word_in          user payload word
//            word_valid_in    word_in valid
//            word_ready_out   load buffer empty
//            clr_underrun_in  clears underrun_out
//            msg_out          navigation bit (to core msg_in)
//            bit_strobe_out   pulse on first cycle of each new bit
//            frame_start_out  pulse on first cycle of preamble bit 7
//            underrun_out     sticky payload-underrun flag
// Revision : 1.0  initial release
// ============================================================================
module gps_nav_msg_gen #(
    parameter int          SAMPLES_PER_EPOCH = 16368,
    parameter int          EPOCHS_PER_BIT    = 20,
    parameter logic [7:0]  PREAMBLE          = 8'h8B,
    parameter logic [31:0] PRESET_WORD       = 32'hFEEDCAFE
) (
    input  logic        clk_in,
    input  logic        rst_in_n,
    input  logic        ena_in,
    input  logic        src_sel_in,
    input  logic [31:0] word_in,
    input  logic        word_valid_in,
    output logic        word_ready_out,
    input  logic        clr_underrun_in,
    output logic        msg_out,
    output logic        bit_strobe_out,
    output logic        frame_start_out,
    output logic        underrun_out
);

    localparam int c_SAMPLE_W = (SAMPLES_PER_EPOCH > 1) ? $clog2(SAMPLES_PER_EPOCH) : 1;
    localparam int c_EPOCH_W  = (EPOCHS_PER_BIT > 1)    ? $clog2(EPOCHS_PER_BIT)    : 1;
    localparam logic [c_SAMPLE_W-1:0] c_SAMPLE_LAST = c_SAMPLE_W'(SAMPLES_PER_EPOCH - 1);
    localparam logic [c_EPOCH_W-1:0]  c_EPOCH_LAST  = c_EPOCH_W'(EPOCHS_PER_BIT - 1);
    localparam logic [4:0]            c_PRE_TOP     = 5'd7;
    localparam logic [4:0]            c_PAY_TOP     = 5'd31;

    typedef enum logic [0:0] {
        ST_PRE = 1'b0,
        ST_PAY = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [c_SAMPLE_W-1:0] r_sample_cnt_q;
    logic [c_EPOCH_W-1:0]  r_epoch_cnt_q;
    state_t                r_state_q;
    logic [4:0]            r_bit_idx_q;
    logic [31:0]           r_payload_q;
    logic                  r_msg_q;
    logic                  r_strobe_q;
    logic                  r_frame_q;
    logic                  r_underrun_q;
    logic                  r_buf_full_q;
    logic [31:0]           r_buf_word_q;

    // ------------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------------
    logic [c_SAMPLE_W-1:0] w_sample_cnt_d;
    logic [c_EPOCH_W-1:0]  w_epoch_cnt_d;
    state_t                w_state_d;
    logic [4:0]            w_bit_idx_d;
    logic [31:0]           w_payload_d;
    logic                  w_msg_d;
    logic                  w_strobe_d;
    logic                  w_frame_d;
    logic                  w_underrun_d;
    logic                  w_buf_full_d;
    logic [31:0]           w_buf_word_d;

    logic w_sample_last;
    logic w_epoch_last;
    logic w_boundary;
    logic w_pay_load;
    logic w_take_buf;
    logic w_underrun_set;
    logic w_accept;

    assign w_sample_last = (r_sample_cnt_q == c_SAMPLE_LAST);
    assign w_epoch_last  = (r_epoch_cnt_q == c_EPOCH_LAST);
    assign w_boundary    = ena_in & w_sample_last & w_epoch_last;

    // Boundary that ends preamble bit 0: the payload word is chosen here.
    assign w_pay_load     = w_boundary & (r_state_q == ST_PRE) & (r_bit_idx_q == 5'd0);
    // Both decisions look at the registered buffer state only, so a word
    // accepted in this same cycle is kept for the following frame.
    assign w_take_buf     = w_pay_load & src_sel_in & r_buf_full_q;
    assign w_underrun_set = w_pay_load & src_sel_in & ~r_buf_full_q;
    assign w_accept       = word_valid_in & ~r_buf_full_q;

    // ------------------------------------------------------------------------
    // Code-phase aligned timing counters
    // ------------------------------------------------------------------------
    always_comb begin
        w_sample_cnt_d = r_sample_cnt_q;
        w_epoch_cnt_d  = r_epoch_cnt_q;
        if (ena_in) begin
            if (w_sample_last) begin
                w_sample_cnt_d = '0;
                w_epoch_cnt_d  = w_epoch_last ? '0 : r_epoch_cnt_q + 1'b1;
            end else begin
                w_sample_cnt_d = r_sample_cnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Frame state machine and registered bit outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_d   = r_state_q;
        w_bit_idx_d = r_bit_idx_q;
        w_payload_d = r_payload_q;
        w_msg_d     = r_msg_q;
        w_strobe_d  = 1'b0;
        w_frame_d   = 1'b0;

        if (w_boundary) begin
            w_strobe_d = 1'b1;
            case (r_state_q)
                ST_PRE: begin
                    if (r_bit_idx_q != 5'd0) begin
                        w_bit_idx_d = r_bit_idx_q - 5'd1;
                    end else begin
                        w_state_d   = ST_PAY;
                        w_bit_idx_d = c_PAY_TOP;
                        w_payload_d = w_take_buf ? r_buf_word_q : PRESET_WORD;
                    end
                end
                ST_PAY: begin
                    if (r_bit_idx_q != 5'd0) begin
                        w_bit_idx_d = r_bit_idx_q - 5'd1;
                    end else begin
                        w_state_d   = ST_PRE;
                        w_bit_idx_d = c_PRE_TOP;
                    end
                end
                default: begin
                    w_state_d   = ST_PRE;
                    w_bit_idx_d = c_PRE_TOP;
                end
            endcase

            // The output bit is looked up from the post-transition position so
            // msg_out changes together with the strobe.
            if (w_state_d == ST_PRE) begin
                w_msg_d   = PREAMBLE[w_bit_idx_d[2:0]];
                w_frame_d = (w_bit_idx_d == c_PRE_TOP);
            end else begin
                w_msg_d   = w_payload_d[w_bit_idx_d];
            end
        end
    end

    // ------------------------------------------------------------------------
    // One-entry load buffer and sticky underrun flag
    // ------------------------------------------------------------------------
    always_comb begin
        w_buf_full_d = r_buf_full_q;
        w_buf_word_d = r_buf_word_q;
        // Consume and accept are mutually exclusive: one needs the buffer
        // full, the other needs it empty.
        if (w_take_buf) begin
            w_buf_full_d = 1'b0;
        end else if (w_accept) begin
            w_buf_full_d = 1'b1;
            w_buf_word_d = word_in;
        end
    end

    always_comb begin
        w_underrun_d = r_underrun_q;
        if (w_underrun_set) begin
            w_underrun_d = 1'b1;
        end else if (clr_underrun_in) begin
            w_underrun_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            r_sample_cnt_q <= '0;
            r_epoch_cnt_q  <= '0;
            r_state_q      <= ST_PRE;
            r_bit_idx_q    <= c_PRE_TOP;
            r_payload_q    <= '0;
            r_msg_q        <= PREAMBLE[7];
            r_strobe_q     <= 1'b0;
            r_frame_q      <= 1'b0;
            r_underrun_q   <= 1'b0;
            r_buf_full_q   <= 1'b0;
            r_buf_word_q   <= '0;
        end else begin
            r_sample_cnt_q <= w_sample_cnt_d;
            r_epoch_cnt_q  <= w_epoch_cnt_d;
            r_state_q      <= w_state_d;
            r_bit_idx_q    <= w_bit_idx_d;
            r_payload_q    <= w_payload_d;
            r_msg_q        <= w_msg_d;
            r_strobe_q     <= w_strobe_d;
            r_frame_q      <= w_frame_d;
            r_underrun_q   <= w_underrun_d;
            r_buf_full_q   <= w_buf_full_d;
            r_buf_word_q   <= w_buf_word_d;
        end
    end

    assign msg_out         = r_msg_q;
    assign bit_strobe_out  = r_strobe_q;
    assign frame_start_out = r_frame_q;
    assign underrun_out    = r_underrun_q;
    assign word_ready_out  = ~r_buf_full_q;

endmodule
`default_nettype wire

// File: tb/tb_gps_nav_msg_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_gps_nav_msg_gen
// Purpose  : Self-checking bench for gps_nav_msg_gen with 8 cycles per bit.
//            A reference model tracks the count of enabled cycles since reset
//            and derives bit position, frame position and payload choice
//            arithmetically; every clock the DUT outputs are compared to it.
// Revision : 1.0  initial release
// ============================================================================
module tb_gps_nav_msg_gen;

    localparam int          SPE        = 4;
    localparam int          EPB        = 2;
    localparam int          BIT_CYC    = SPE * EPB;
    localparam int          FRAME_BITS = 40;
    localparam int          FRAME_CYC  = BIT_CYC * FRAME_BITS;
    localparam logic [7:0]  PRE_PAT    = 8'h8B;
    localparam logic [31:0] PRESET     = 32'hFEEDCAFE;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        src_sel;
    logic [31:0] word;
    logic        valid;
    logic        clr;
    logic        ready;
    logic        msg;
    logic        strobe;
    logic        frame;
    logic        under;

    always #5 clk = ~clk;

    gps_nav_msg_gen #(
        .SAMPLES_PER_EPOCH (SPE),
        .EPOCHS_PER_BIT    (EPB),
        .PREAMBLE          (PRE_PAT),
        .PRESET_WORD       (PRESET)
    ) u_dut (
        .clk_in          (clk),
        .rst_in_n        (rst_n),
        .ena_in          (ena),
        .src_sel_in      (src_sel),
        .word_in         (word),
        .word_valid_in   (valid),
        .word_ready_out  (ready),
        .clr_underrun_in (clr),
        .msg_out         (msg),
        .bit_strobe_out  (strobe),
        .frame_start_out (frame),
        .underrun_out    (under)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    int          m_en;      // enabled clock edges since reset release
    bit          m_full;
    logic [31:0] m_bufw;
    logic [31:0] m_word;    // payload of the current frame
    bit          m_under;
    bit          m_msg;
    bit          m_strobe;
    bit          m_frame;

    function automatic bit frame_bit(input int p, input logic [31:0] w);
        logic [7:0] pv;
        pv = PRE_PAT;
        if (p < 8) return pv[7 - p];
        return w[31 - (p - 8)];
    endfunction

    task automatic model_reset();
        m_en = 0; m_full = 0; m_bufw = '0; m_word = PRESET;
        m_under = 0; m_msg = 1; m_strobe = 0; m_frame = 0;
    endtask

    task automatic model_edge();
        bit bnd;
        bit acc;
        bit take;
        bit set_u;
        int p;
        take  = 0;
        set_u = 0;
        acc   = valid && !m_full;
        bnd   = ena && (((m_en + 1) % BIT_CYC) == 0);
        m_strobe = bnd;
        m_frame  = 0;
        if (bnd) begin
            p = ((m_en + 1) / BIT_CYC) % FRAME_BITS;
            if (p == 8) begin
                if (!src_sel) m_word = PRESET;
                else if (m_full) begin m_word = m_bufw; take = 1; end
                else begin m_word = PRESET; set_u = 1; end
            end
            m_msg   = frame_bit(p, m_word);
            m_frame = (p == 0);
        end
        if (take) m_full = 0;
        else if (acc) begin m_full = 1; m_bufw = word; end
        if (set_u) m_under = 1;
        else if (clr) m_under = 0;
        if (ena) m_en++;
    endtask

    task automatic compare_all();
        check("msg_out", msg, m_msg);
        check("bit_strobe_out", strobe, m_strobe);
        check("frame_start_out", frame, m_frame);
        check("underrun_out", under, m_under);
        check("word_ready_out", ready, !m_full);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic run_to(input int target);
        int guard;
        guard = 0;
        ena   = 1'b1;
        while (m_en < target && guard < 5000) begin
            step();
            guard++;
        end
        if (m_en != target) begin
            n_checks++;
            $display("FAIL run_to: reached %0d required %0d", m_en, target);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_msg"}, msg, 1'b1);
        check({tag, "_strobe"}, strobe, 1'b0);
        check({tag, "_frame"}, frame, 1'b0);
        check({tag, "_underrun"}, under, 1'b0);
        check({tag, "_ready"}, ready, 1'b1);
    endtask

    // Directed table: enabled-edge count since release -> expected outputs.
    typedef struct {
        int edge_n;
        bit msg;
        bit strobe;
        bit frame;
    } vec_t;

    vec_t tbl [18] = '{
        '{0,   1'b1, 1'b0, 1'b0},
        '{7,   1'b1, 1'b0, 1'b0},
        '{8,   1'b0, 1'b1, 1'b0},
        '{9,   1'b0, 1'b0, 1'b0},
        '{24,  1'b0, 1'b1, 1'b0},
        '{32,  1'b1, 1'b1, 1'b0},
        '{40,  1'b0, 1'b1, 1'b0},
        '{56,  1'b1, 1'b1, 1'b0},
        '{64,  1'b1, 1'b1, 1'b0},
        '{120, 1'b0, 1'b1, 1'b0},
        '{152, 1'b0, 1'b1, 1'b0},
        '{176, 1'b0, 1'b1, 1'b0},
        '{208, 1'b0, 1'b1, 1'b0},
        '{248, 1'b0, 1'b1, 1'b0},
        '{312, 1'b0, 1'b1, 1'b0},
        '{319, 1'b0, 1'b0, 1'b0},
        '{320, 1'b1, 1'b1, 1'b1},
        '{321, 1'b1, 1'b0, 1'b0}
    };

    bit obs_msg    [0:FRAME_CYC + 1];
    bit obs_strobe [0:FRAME_CYC + 1];
    bit obs_frame  [0:FRAME_CYC + 1];

    initial begin
        int cnt;
        bit held;
        rst_n = 1'b0; ena = 1'b0; src_sel = 1'b0; word = '0; valid = 1'b0; clr = 1'b0;
        model_reset();
        @(posedge clk); #1;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        ena   = 1'b1;

        // ---- Preset frame against the constant table ----
        obs_msg[0] = msg; obs_strobe[0] = strobe; obs_frame[0] = frame;
        for (int i = 1; i <= FRAME_CYC + 1; i++) begin
            step();
            obs_msg[i] = msg; obs_strobe[i] = strobe; obs_frame[i] = frame;
        end
        for (int i = 0; i < 18; i++) begin
            check($sformatf("tbl%0d_msg", tbl[i].edge_n), obs_msg[tbl[i].edge_n], tbl[i].msg);
            check($sformatf("tbl%0d_strobe", tbl[i].edge_n), obs_strobe[tbl[i].edge_n], tbl[i].strobe);
            check($sformatf("tbl%0d_frame", tbl[i].edge_n), obs_frame[tbl[i].edge_n], tbl[i].frame);
        end

        // ---- User word loaded during preamble ----
        src_sel = 1'b1;
        valid = 1'b1; word = 32'h12345678;
        step();
        valid = 1'b0; word = 32'hDEADBEEF;
        check("load_ready_low", ready, 1'b0);
        step();
        check("load_ready_still_low", ready, 1'b0);
        run_to(FRAME_CYC + 64);
        check("user_ready_back", ready, 1'b1);
        check("user_bit31", msg, 1'b0);
        run_to(FRAME_CYC + 64 + 3 * BIT_CYC);
        check("user_bit28", msg, 1'b1);            // 0x1 nibble LSB
        run_to(2 * FRAME_CYC);
        check("user_no_underrun", under, 1'b0);

        // ---- Underrun: no word supplied ----
        run_to(2 * FRAME_CYC + 63);
        check("underrun_before", under, 1'b0);
        step();
        check("underrun_set", under, 1'b1);
        check("underrun_preset_msb", msg, 1'b1);
        clr = 1'b1; step(); clr = 1'b0;
        check("underrun_cleared", under, 1'b0);

        // ---- Enable held low 13 cycles mid-bit ----
        run_to(2 * FRAME_CYC + 80);
        check("gap_strobe_ref", strobe, 1'b1);
        for (int i = 0; i < 3; i++) step();
        held = msg;
        ena = 1'b0;
        for (int i = 0; i < 13; i++) step();
        check("gap_msg_held", msg, held);
        ena = 1'b1;
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!strobe && cnt < 50);
        check("gap_strobe_spacing", 3 + 13 + cnt, 21);

        // ---- Word offered on the consuming boundary cycle ----
        run_to(3 * FRAME_CYC + 63);
        check("race_ready_before", ready, 1'b1);
        valid = 1'b1; word = 32'hA5C30F96;
        step();
        valid = 1'b0; word = '0;
        check("race_underrun", under, 1'b1);
        check("race_word_kept", ready, 1'b0);
        clr = 1'b1; step(); clr = 1'b0;
        run_to(4 * FRAME_CYC + 64 + BIT_CYC);
        check("race_next_bit30", msg, 1'b0);       // preset would give 1
        check("race_no_underrun", under, 1'b0);
        check("race_ready_back", ready, 1'b1);

        // ---- Asynchronous reset during payload bit 10 ----
        src_sel = 1'b0;
        run_to(4 * FRAME_CYC + 64 + 10 * BIT_CYC + 2);
        valid = 1'b1; word = 32'h0F0F0F0F;
        step();
        valid = 1'b0;
        check("pre_reset_full", ready, 1'b0);
        src_sel = 1'b1;
        rst_n = 1'b0;
        #2;
        check_reset_outputs("async_reset");
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_to(BIT_CYC);
        check("restart_bit1", msg, 1'b0);
        run_to(64);
        check("restart_discarded_word", under, 1'b1);
        check("restart_preset_msb", msg, 1'b1);
        clr = 1'b1; step(); clr = 1'b0;

        // ---- Randomized traffic against the model ----
        for (int i = 0; i < 3000; i++) begin
            ena     = ($urandom_range(0, 9) != 0);
            src_sel = ($urandom_range(0, 3) != 0);
            valid   = ($urandom_range(0, 3) == 0);
            word    = $urandom;
            clr     = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
